// File: rtl/coherency_pkg.sv
// Coherency controller types: controller state and core index.
package coherency_pkg;
  localparam int MAX_CPUS = 8;
  localparam int CPUID_W  = $clog2(MAX_CPUS);

  typedef logic [CPUID_W-1:0] cpuid_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WB    = 3'd1,
    IF    = 3'd2,
    SNOOP = 3'd3,
    C2C   = 3'd4,
    M2C   = 3'd5
  } cc_state_t;

  // Successor of a core index, wrapping modulo n.
  function automatic cpuid_t next_id(input cpuid_t id, input int n);
    int nxt;
    nxt = int'(id) + 1;
    if (nxt >= n) nxt = 0;
    return cpuid_t'(nxt);
  endfunction
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and RAM handshake state.
package cpu_types_pkg;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

// File: rtl/coherency_controller_n_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter
  import coherency_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  cpuid_t       ptr,
  output logic         valid,
  output cpuid_t       grant
);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    valid = 1'b0;
    grant = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      for (int j = 0; j < N; j++) begin
        if (j == idx && req[j]) begin
          valid = 1'b1;
          grant = cpuid_t'(j);
        end
      end
    end
  end

endmodule

// File: rtl/coherency_controller_n.sv
// N-core bus/coherency controller between L1 caches and one RAM port.
module coherency_controller_n
  import cpu_types_pkg::*;
  import coherency_pkg::*;
#(
  parameter int NCPUS       = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [NCPUS-1:0] iREN,
  input  word_t            iaddr       [NCPUS],
  input  logic [NCPUS-1:0] dREN,
  input  logic [NCPUS-1:0] dWEN,
  input  word_t            daddr       [NCPUS],
  input  word_t            dstore      [NCPUS],
  input  logic [NCPUS-1:0] ccwrite,
  input  logic [NCPUS-1:0] cctrans,
  output logic [NCPUS-1:0] iwait,
  output logic [NCPUS-1:0] dwait,
  output word_t            iload       [NCPUS],
  output word_t            dload       [NCPUS],
  output logic [NCPUS-1:0] ccwait,
  output logic [NCPUS-1:0] ccinv,
  output word_t            ccsnoopaddr [NCPUS],
  input  word_t            ramload,
  input  ramstate_t        ramstate,
  output word_t            ramaddr,
  output word_t            ramstore,
  output logic             ramREN,
  output logic             ramWEN
);

  localparam int BEAT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

  cc_state_t         state_q, state_d;
  cpuid_t            req_q, req_d;
  cpuid_t            sup_q, sup_d;
  cpuid_t            rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic [NCPUS-1:0] class_req;
  cc_state_t        class_state;
  logic             arb_valid;
  cpuid_t           arb_grant;

  logic [NCPUS-1:0] is_req, is_sup;
  word_t            req_daddr, req_dstore, req_iaddr, sup_daddr, sup_dstore;
  logic             req_dren, req_dwen, req_iren, req_ccwrite, sup_dwen;
  logic             snoop_done, supply_any;
  cpuid_t           supply_id;
  logic             access, strobe_ok;

  assign access = (ramstate == ACCESS);

  // Present the highest-priority request class (writeback > snoop read > fetch).
  always_comb begin
    if (|dWEN) begin
      class_req   = dWEN;
      class_state = WB;
    end else if (|dREN) begin
      class_req   = dREN;
      class_state = SNOOP;
    end else begin
      class_req   = iREN;
      class_state = IF;
    end
  end

  rr_arbiter #(.N(NCPUS)) u_arb (
    .req   (class_req),
    .ptr   (rr_ptr_q),
    .valid (arb_valid),
    .grant (arb_grant)
  );

  // Select requester/supplier signals and evaluate snoop completion.
  always_comb begin
    is_req      = '0;
    is_sup      = '0;
    req_daddr   = '0;
    req_dstore  = '0;
    req_iaddr   = '0;
    req_dren    = 1'b0;
    req_dwen    = 1'b0;
    req_iren    = 1'b0;
    req_ccwrite = 1'b0;
    sup_daddr   = '0;
    sup_dstore  = '0;
    sup_dwen    = 1'b0;
    snoop_done  = 1'b1;
    supply_any  = 1'b0;
    supply_id   = '0;
    for (int j = 0; j < NCPUS; j++) begin
      is_req[j] = (cpuid_t'(j) == req_q);
      is_sup[j] = (cpuid_t'(j) == sup_q);
      if (is_req[j]) begin
        req_daddr   = daddr[j];
        req_dstore  = dstore[j];
        req_iaddr   = iaddr[j];
        req_dren    = dREN[j];
        req_dwen    = dWEN[j];
        req_iren    = iREN[j];
        req_ccwrite = ccwrite[j];
      end else begin
        snoop_done = snoop_done & cctrans[j];
      end
      if (is_sup[j]) begin
        sup_daddr  = daddr[j];
        sup_dstore = dstore[j];
        sup_dwen   = dWEN[j];
      end
    end
    // Lowest-numbered snooped core offering data becomes the supplier.
    for (int j = NCPUS - 1; j >= 0; j--) begin
      if (!is_req[j] && dWEN[j]) begin
        supply_any = 1'b1;
        supply_id  = cpuid_t'(j);
      end
    end
  end

  // State register; reset aborts any transaction immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      req_q    <= '0;
      sup_q    <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      sup_q    <= sup_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

  // Next-state logic: grant, snoop resolution, beat counting and abort.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    sup_d    = sup_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    unique case (state_q)
      WB:      strobe_ok = req_dwen;
      IF:      strobe_ok = req_iren;
      M2C:     strobe_ok = req_dren;
      C2C:     strobe_ok = req_dren && sup_dwen;
      SNOOP:   strobe_ok = req_dren;
      default: strobe_ok = 1'b1;
    endcase
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = class_state;
          req_d   = arb_grant;
          beat_d  = '0;
        end
      end
      SNOOP: begin
        if (!strobe_ok) begin
          state_d = IDLE;
          beat_d  = '0;
        end else if (snoop_done) begin
          if (supply_any) begin
            state_d = C2C;
            sup_d   = supply_id;
          end else begin
            state_d = M2C;
          end
        end
      end
      WB, IF, C2C, M2C: begin
        if (!strobe_ok) begin
          state_d = IDLE;
          beat_d  = '0;
        end else if (access) begin
          if (beat_q == LAST_BEAT) begin
            state_d  = IDLE;
            beat_d   = '0;
            rr_ptr_d = next_id(req_q, NCPUS);
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = req_daddr;
        ramstore = req_dstore;
      end
      IF: begin
        ramREN  = 1'b1;
        ramaddr = req_iaddr;
      end
      C2C: begin
        ramWEN   = 1'b1;
        ramaddr  = sup_daddr;
        ramstore = sup_dstore;
      end
      M2C: begin
        ramREN  = 1'b1;
        ramaddr = req_daddr;
      end
      default: ;
    endcase
    for (int j = 0; j < NCPUS; j++) begin
      iwait[j]       = 1'b0;
      dwait[j]       = 1'b0;
      iload[j]       = '0;
      dload[j]       = '0;
      ccwait[j]      = 1'b0;
      ccinv[j]       = 1'b0;
      ccsnoopaddr[j] = '0;
      if (state_q != IDLE) begin
        // Any request not being served stalls.
        iwait[j] = iREN[j];
        dwait[j] = dREN[j] | dWEN[j];
        if (!is_req[j]) ccwait[j] = (state_q == SNOOP) || (state_q == C2C) || (state_q == M2C);
      end
      if (is_req[j]) begin
        unique case (state_q)
          WB:    dwait[j] = !access;
          IF: begin
            iwait[j] = !access;
            iload[j] = ramload;
          end
          SNOOP: dwait[j] = 1'b1;
          C2C: begin
            dwait[j] = !access;
            dload[j] = sup_dstore;
          end
          M2C: begin
            dwait[j] = !access;
            dload[j] = ramload;
          end
          default: ;
        endcase
      end else if (state_q == SNOOP) begin
        ccsnoopaddr[j] = req_daddr;
        ccinv[j]       = req_ccwrite;
      end
      if (state_q == C2C && is_sup[j] && !is_req[j]) dwait[j] = !access;
    end
  end

endmodule

// File: tb/tb_coherency_controller_n.sv
// Directed bench for coherency_controller_n with four cores, two-word blocks.
module tb_coherency_controller_n;
  import cpu_types_pkg::*;
  import coherency_pkg::*;

  localparam int N  = 4;
  localparam int BW = 2;

  logic         CLK = 1'b0;
  logic         nRST;
  logic [N-1:0] iREN, dREN, dWEN, ccwrite, cctrans;
  word_t        iaddr [N];
  word_t        daddr [N];
  word_t        dstore [N];
  logic [N-1:0] iwait, dwait, ccwait, ccinv;
  word_t        iload [N];
  word_t        dload [N];
  word_t        ccsnoopaddr [N];
  word_t        ramload, ramaddr, ramstore;
  ramstate_t    ramstate;
  logic         ramREN, ramWEN;

  int checks = 0;
  int fails  = 0;

  always #5 CLK = ~CLK;

  coherency_controller_n #(.NCPUS(N), .BLOCK_WORDS(BW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ccwrite(ccwrite), .cctrans(cctrans),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramload(ramload), .ramstate(ramstate), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int exp_id;
    nRST     = 1'b0;
    iREN     = '1;
    dREN     = '1;
    dWEN     = '1;
    ccwrite  = '0;
    cctrans  = '0;
    ramstate = BUSY;
    ramload  = 32'hCAFE0000;
    for (int j = 0; j < N; j++) begin
      iaddr[j]  = 32'h8000 + 32'(4 * j);
      daddr[j]  = (j == 0) ? 32'h40 : 32'(j * 32'h100);
      dstore[j] = 32'h11110000 + 32'(j);
    end

    // Reset with everything requesting: all outputs quiet.
    #3;
    chk("rst_state", dut.state_q, IDLE);
    chk("rst_iwait", iwait, 4'h0);
    chk("rst_dwait", dwait, 4'h0);
    chk("rst_ramstrobes", {ramREN, ramWEN}, 2'b00);
    chk("rst_ccwait", ccwait, 4'h0);
    chk("rst_ccinv", ccinv, 4'h0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_iload0", iload[0], 32'h0);
    #9 nRST = 1'b1;

    // Writeback from core 0 wins first; BUSY/ERROR do not count beats.
    step();
    chk("wb_state", dut.state_q, WB);
    chk("wb_ramWEN", ramWEN, 1'b1);
    chk("wb_ramaddr", ramaddr, 32'h40);
    chk("wb_ramstore", ramstore, 32'h11110000);
    chk("wb_dwait_all", dwait, 4'hF);
    iREN = '0; dREN = '0; dWEN = 4'b0001;
    #1 chk("wb_busy_dwait", dwait, 4'b0001);
    step();
    chk("wb_busy_beat", dut.beat_q, 0);
    ramstate = ERROR;
    #1 chk("wb_err_dwait", dwait, 4'b0001);
    step();
    chk("wb_err_beat", dut.beat_q, 0);
    ramstate = ACCESS;
    #1 chk("wb_acc_dwait", dwait, 4'b0000);
    step();
    chk("wb_beat1", dut.beat_q, 1);
    chk("wb_still", dut.state_q, WB);
    step();
    chk("wb_done", dut.state_q, IDLE);
    chk("wb_rrptr", dut.rr_ptr_q, 1);
    dWEN = '0;

    // Instruction fetches from all cores: round-robin from pointer 1.
    iREN = 4'hF;
    for (int k = 0; k < 5; k++) begin
      exp_id = (k + 1) % N;
      step();
      chk("if_state", dut.state_q, IF);
      chk("if_ramaddr", ramaddr, 32'h8000 + 32'(4 * exp_id));
      chk("if_iwait", iwait, 4'hF & ~(4'b1 << exp_id));
      chk("if_iload", iload[exp_id], 32'hCAFE0000);
      step();
      step();
      chk("if_done", dut.state_q, IDLE);
    end
    iREN = '0;
    chk("if_rrptr", dut.rr_ptr_q, 2);

    // Core 1 read-exclusive snoop, no supplier: memory to cache.
    dREN = 4'b0010; ccwrite = 4'b0010; ramstate = BUSY;
    step();
    chk("sn_state", dut.state_q, SNOOP);
    chk("sn_ccwait", ccwait, 4'b1101);
    chk("sn_ccinv", ccinv, 4'b1101);
    chk("sn_addr0", ccsnoopaddr[0], 32'h100);
    chk("sn_addr2", ccsnoopaddr[2], 32'h100);
    chk("sn_addr3", ccsnoopaddr[3], 32'h100);
    chk("sn_addr1", ccsnoopaddr[1], 32'h0);
    chk("sn_dwait", dwait, 4'b0010);
    step();
    chk("sn_hold", dut.state_q, SNOOP);
    cctrans = 4'b1101;
    step();
    chk("m2c_state", dut.state_q, M2C);
    chk("m2c_ramREN", ramREN, 1'b1);
    chk("m2c_ramaddr", ramaddr, 32'h100);
    chk("m2c_ccwait", ccwait, 4'b1101);
    chk("m2c_busy_dwait", dwait, 4'b0010);
    ramstate = ACCESS;
    #1 chk("m2c_acc_dwait", dwait, 4'b0000);
    chk("m2c_dload", dload[1], 32'hCAFE0000);
    step();
    chk("m2c_beat1", dut.state_q, M2C);
    step();
    chk("m2c_done", dut.state_q, IDLE);
    chk("m2c_rrptr", dut.rr_ptr_q, 2);
    dREN = '0; ccwrite = '0; cctrans = '0;

    // Core 0 snoop with cores 2 and 3 both supplying: core 2 supplies.
    dREN = 4'b0001; ramstate = BUSY;
    step();
    chk("c2c_snoop", dut.state_q, SNOOP);
    dWEN = 4'b1100; cctrans = 4'b1110;
    dstore[2] = 32'hDEADBEEF; dstore[3] = 32'hDEADBEEF;
    step();
    chk("c2c_state", dut.state_q, C2C);
    chk("c2c_sup", dut.sup_q, 2);
    chk("c2c_dload", dload[0], 32'hDEADBEEF);
    chk("c2c_ramWEN", ramWEN, 1'b1);
    chk("c2c_ramstore", ramstore, 32'hDEADBEEF);
    chk("c2c_ramaddr", ramaddr, 32'h200);
    chk("c2c_ccwait", ccwait, 4'b1110);
    chk("c2c_busy_dwait", dwait, 4'b1101);
    ramstate = ACCESS;
    #1 chk("c2c_acc_dwait", dwait, 4'b1000);
    step();
    step();
    chk("c2c_done", dut.state_q, IDLE);
    chk("c2c_rrptr", dut.rr_ptr_q, 1);
    dWEN = '0; dREN = '0; cctrans = '0;

    // Core 0 abandons its M2C read after the first beat.
    dREN = 4'b0001; cctrans = 4'b1110;
    step();
    step();
    chk("ab_m2c", dut.state_q, M2C);
    step();
    chk("ab_beat1", dut.beat_q, 1);
    dREN = '0;
    step();
    chk("ab_state", dut.state_q, IDLE);
    chk("ab_beat", dut.beat_q, 0);
    chk("ab_rrptr", dut.rr_ptr_q, 1);
    cctrans = '0;

    // Asynchronous reset in the middle of a writeback.
    dWEN = 4'b0010; ramstate = BUSY;
    step();
    chk("ar_wb", dut.state_q, WB);
    #2 nRST = 1'b0;
    #1 chk("ar_state", dut.state_q, IDLE);
    chk("ar_ramWEN", ramWEN, 1'b0);
    chk("ar_rrptr", dut.rr_ptr_q, 0);
    dWEN = '0;
    #3 nRST = 1'b1;
    step();
    chk("ar_idle", dut.state_q, IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
